// File: rtl/mem_wb_stage.sv
// Memory / writeback stage: byte-enabled data RAM plus MEM/WB register driving the decode register-file write port.
// Optional misaligned-access trap enabled by defining MEM_WB_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module mem_wb_stage #(
  parameter int unsigned DMEM_SIZE = 512,
  parameter int unsigned ADDR_W    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_reg2,
  input  logic [31:0] i_pc4,
  input  logic [2:0]  i_func3,
  input  logic        i_mem_w_en,
  input  logic [4:0]  i_w_idx,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_wb_en,
  output logic        o_wr_en,
  output logic [4:0]  o_wr_idx,
  output logic [31:0] o_wr_data
`ifdef MEM_WB_MISALIGN_TRAP_EN
  ,
  output logic        o_misaligned
`endif
);

  logic [31:0]       mem [DMEM_SIZE];
  logic [ADDR_W-1:0] mem_idx;
  logic [1:0]        a_lo;
  logic              mis_ld, mis_st;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              st_commit;

  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic              wb_en_d, wb_en_q;
  logic [4:0]        w_idx_d, w_idx_q;
  logic [1:0]        wb_sel_d, wb_sel_q;
  logic [2:0]        func3_d, func3_q;
  logic [1:0]        addr_lo_d, addr_lo_q;
  logic [31:0]       alu_d, alu_q;
  logic [31:0]       pc4_d, pc4_q;

  logic [31:0]       rdata;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_data;

  assign mem_idx = i_alu_result[ADDR_W+1:2];
  assign a_lo    = i_alu_result[1:0];

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic mis_d, mis_q;

  // Loads: func3[1]=1 is a full-word access; stores only trap on real SH/SW encodings.
  always_comb begin
    mis_ld = 1'b0;
    mis_st = 1'b0;
    if (i_wb_sel == 2'b01)
      mis_ld = ((i_func3[1:0] == 2'b01) && a_lo[0]) || (i_func3[1] && (a_lo != 2'b00));
    if (i_mem_w_en)
      mis_st = ((i_func3 == 3'b001) && a_lo[0]) || ((i_func3 == 3'b010) && (a_lo != 2'b00));
  end

  always_comb begin
    mis_d = mis_q;
    if (flush)
      mis_d = 1'b0;
    else if (!stall)
      mis_d = mis_ld | mis_st;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign o_misaligned = mis_q;
`else
  assign mis_ld = 1'b0;
  assign mis_st = 1'b0;
`endif

  always_comb begin
    be    = '0;
    wdata = i_reg2;
    case (i_func3)
      3'b000: begin
        be    = 4'b0001 << a_lo;
        wdata = {4{i_reg2[7:0]}};
      end
      3'b001: begin
        be    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_reg2[15:0]}};
      end
      3'b010:  be = '1;
      default: be = '0;
    endcase
    // A store is dropped if reset is low at its edge.
    st_commit = i_mem_w_en & ~stall & ~flush & ~mis_st & rst;
  end

  always_ff @(posedge clk) begin
    if (st_commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    wb_en_d   = wb_en_q;
    w_idx_d   = w_idx_q;
    wb_sel_d  = wb_sel_q;
    func3_d   = func3_q;
    addr_lo_d = addr_lo_q;
    alu_d     = alu_q;
    pc4_d     = pc4_q;
    if (flush) begin
      wb_en_d = 1'b0;
    end else if (!stall) begin
      rd_addr_d = mem_idx;
      wb_en_d   = i_wb_en & ~mis_ld;
      w_idx_d   = i_w_idx;
      wb_sel_d  = i_wb_sel;
      func3_d   = i_func3;
      addr_lo_d = a_lo;
      alu_d     = i_alu_result;
      pc4_d     = i_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      wb_en_q   <= 1'b0;
      w_idx_q   <= '0;
      wb_sel_q  <= '0;
      func3_q   <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wb_en_q   <= wb_en_d;
      w_idx_q   <= w_idx_d;
      wb_sel_q  <= wb_sel_d;
      func3_q   <= func3_d;
      addr_lo_q <= addr_lo_d;
      alu_q     <= alu_d;
      pc4_q     <= pc4_d;
    end
  end

  // Registered read address makes the RAM read synchronous; a store at N is visible to a load at N+1.
  assign rdata    = mem[rd_addr_q];
  assign sel_byte = rdata[{addr_lo_q, 3'b000} +: 8];
  assign sel_half = addr_lo_q[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (func3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    case (wb_sel_q)
      2'b01:   o_wr_data = load_data;
      2'b10:   o_wr_data = pc4_q;
      default: o_wr_data = alu_q;
    endcase
  end

  assign o_wr_en  = wb_en_q & (w_idx_q != 5'd0);
  assign o_wr_idx = w_idx_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: byte-array memory model, expected results queued per cycle, monitor compares.
`timescale 1ns/1ps
module tb_mem_wb_stage;
  localparam int unsigned DMEM_SIZE = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [31:0] i_alu_result, i_reg2, i_pc4;
  logic [2:0]  i_func3;
  logic        i_mem_w_en;
  logic [4:0]  i_w_idx;
  logic [1:0]  i_wb_sel;
  logic        i_wb_en;
  logic        o_wr_en;
  logic [4:0]  o_wr_idx;
  logic [31:0] o_wr_data;
  logic        o_misaligned;

  always #5 clk = ~clk;

  mem_wb_stage #(.DMEM_SIZE(DMEM_SIZE), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .i_alu_result(i_alu_result), .i_reg2(i_reg2), .i_pc4(i_pc4),
    .i_func3(i_func3), .i_mem_w_en(i_mem_w_en), .i_w_idx(i_w_idx),
    .i_wb_sel(i_wb_sel), .i_wb_en(i_wb_en),
    .o_wr_en(o_wr_en), .o_wr_idx(o_wr_idx), .o_wr_data(o_wr_data)
`ifdef MEM_WB_MISALIGN_TRAP_EN
    , .o_misaligned(o_misaligned)
`endif
  );
`ifndef MEM_WB_MISALIGN_TRAP_EN
  assign o_misaligned = 1'b0;
`endif

  typedef struct {
    logic [31:0] alu, reg2, pc4;
    logic [2:0]  func3;
    logic        mem_w_en;
    logic [4:0]  w_idx;
    logic [1:0]  wb_sel;
    logic        wb_en, stall, flush;
  } instr_t;

  typedef struct {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        mis;
    logic        chk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        prev;
  exp_t        mon_e;
  logic [7:0]  mem_b [DMEM_SIZE*4];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t idle();
    instr_t t;
    t = '{alu: 32'h0, reg2: 32'h0, pc4: 32'h0, func3: 3'b000, mem_w_en: 1'b0,
          w_idx: 5'd0, wb_sel: 2'b00, wb_en: 1'b0, stall: 1'b0, flush: 1'b0};
    return t;
  endfunction

  function automatic instr_t st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    instr_t t = idle();
    t.alu = a; t.reg2 = d; t.func3 = f3; t.mem_w_en = 1'b1;
    return t;
  endfunction

  function automatic instr_t ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    instr_t t = idle();
    t.alu = a; t.func3 = f3; t.wb_sel = 2'b01; t.wb_en = 1'b1; t.w_idx = rd;
    return t;
  endfunction

  function automatic instr_t jal(input logic [31:0] pc4, input logic [4:0] rd);
    instr_t t = idle();
    t.alu = 32'h0000_5A5A; t.pc4 = pc4; t.wb_sel = 2'b10; t.wb_en = 1'b1; t.w_idx = rd;
    return t;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int unsigned w, input int unsigned lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] word;
    b    = mem_b[w*4 + lo];
    h    = {mem_b[w*4 + (lo/2)*2 + 1], mem_b[w*4 + (lo/2)*2]};
    word = {mem_b[w*4 + 3], mem_b[w*4 + 2], mem_b[w*4 + 1], mem_b[w*4]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Architectural effect of one instruction at its clock edge.
  task automatic model(input instr_t t);
    exp_t        e;
    int unsigned w, lo;
    logic        mis_ld, mis_st;
    w      = (t.alu >> 2) % DMEM_SIZE;
    lo     = t.alu % 4;
    mis_ld = 1'b0;
    mis_st = 1'b0;
    if (t.flush) begin
      e = '{en: 1'b0, idx: 5'd0, data: 32'h0, mis: 1'b0, chk: 1'b0};
    end else if (t.stall) begin
      e = prev;
    end else begin
`ifdef MEM_WB_MISALIGN_TRAP_EN
      if (t.wb_sel == 2'b01) begin
        if (t.func3 == 3'b001 || t.func3 == 3'b101) mis_ld = (lo % 2) != 0;
        if (t.func3 inside {3'b010, 3'b011, 3'b110, 3'b111}) mis_ld = lo != 0;
      end
      if (t.mem_w_en) begin
        if (t.func3 == 3'b001) mis_st = (lo % 2) != 0;
        if (t.func3 == 3'b010) mis_st = lo != 0;
      end
`endif
      e.en  = t.wb_en && (t.w_idx != 5'd0) && !mis_ld;
      e.idx = t.w_idx;
      e.mis = mis_ld || mis_st;
      e.chk = !mis_ld;
      case (t.wb_sel)
        2'b01:   e.data = load_val(t.func3, w, lo);
        2'b10:   e.data = t.pc4;
        default: e.data = t.alu;
      endcase
      if (t.mem_w_en && !mis_st) begin
        case (t.func3)
          3'b000: mem_b[w*4 + lo] = t.reg2[7:0];
          3'b001: begin
            mem_b[w*4 + (lo/2)*2]     = t.reg2[7:0];
            mem_b[w*4 + (lo/2)*2 + 1] = t.reg2[15:8];
          end
          3'b010: for (int k = 0; k < 4; k++) mem_b[w*4 + k] = t.reg2[8*k +: 8];
          default: ;
        endcase
      end
    end
    prev = e;
    exp_q.push_back(e);
  endtask

  task automatic drive(input instr_t t);
    i_alu_result = t.alu;   i_reg2 = t.reg2;     i_pc4 = t.pc4;
    i_func3      = t.func3; i_mem_w_en = t.mem_w_en;
    i_w_idx      = t.w_idx; i_wb_sel = t.wb_sel; i_wb_en = t.wb_en;
    stall        = t.stall; flush = t.flush;
  endtask

  task automatic step(input instr_t t);
    drive(t);
    @(posedge clk);
    model(t);
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t      t;
    int unsigned w, lo;
    t  = idle();
    w  = $urandom_range(0, 31);
    lo = $urandom_range(0, 3);
    t.alu   = ($urandom & ~32'h7FF) | (w << 2) | lo;
    t.reg2  = $urandom;
    t.pc4   = $urandom;
    t.w_idx = 5'($urandom_range(0, 31));
    t.wb_en = ($urandom_range(0, 3) != 0);
    t.func3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: t.wb_sel = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      1: t.wb_sel = 2'b01;
      2: t.wb_sel = 2'b10;
      default: begin
        t.mem_w_en = 1'b1;
        t.wb_en    = 1'b0;
        t.wb_sel   = 2'b00;
        t.func3    = 3'($urandom_range(0, 3));
      end
    endcase
    t.stall = ($urandom_range(0, 99) < 15);
    t.flush = ($urandom_range(0, 99) < 8);
    return t;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("wr_en", 32'(o_wr_en), 32'(mon_e.en));
        check("misaligned", 32'(o_misaligned), 32'(mon_e.mis));
        if (mon_e.chk) begin
          check("wr_idx", 32'(o_wr_idx), 32'(mon_e.idx));
          check("wr_data", o_wr_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected results never observed", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    instr_t t;
    rst  = 1'b0;
    prev = '{en: 1'b0, idx: 5'd0, data: 32'h0, mis: 1'b0, chk: 1'b1};
    drive(rand_instr());
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_wr_en", 32'(o_wr_en), 32'h0);
      check("rst_wr_idx", 32'(o_wr_idx), 32'h0);
      check("rst_wr_data", o_wr_data, 32'h0);
      drive(rand_instr());
    end
    drive(idle());
    rst = 1'b1;
    repeat (2) begin
      step(idle());
      check("idle_wr_en", 32'(o_wr_en), 32'h0);
    end

    for (int w = 0; w < 32; w++) step(st(32'(w << 2), $urandom, 3'b010));

    step(st(32'h10, 32'h8899AABB, 3'b010));
    step(ld(32'h13, 3'b000, 5'd5));
    check("lb_en", 32'(o_wr_en), 32'h1);
    check("lb_idx", 32'(o_wr_idx), 32'h5);
    check("lb_data", o_wr_data, 32'hFFFFFF88);
    step(ld(32'h13, 3'b100, 5'd6));
    check("lbu_data", o_wr_data, 32'h00000088);
    step(ld(32'h10, 3'b001, 5'd6));
    check("lh_data", o_wr_data, 32'hFFFFAABB);
    step(st(32'h11, 32'h12, 3'b000));
    step(ld(32'h810, 3'b010, 5'd7));
    check("sb_alias_lw", o_wr_data, 32'h889912BB);
    step(jal(32'h104, 5'd1));
    check("jal_en", 32'(o_wr_en), 32'h1);
    check("jal_data", o_wr_data, 32'h104);
    step(jal(32'h104, 5'd0));
    check("jal_x0_en", 32'(o_wr_en), 32'h0);

    step(st(32'h20, 32'h11223344, 3'b010));
    step(ld(32'h20, 3'b010, 5'd7));
    check("lw_pre", o_wr_data, 32'h11223344);
    t = st(32'h20, 32'hCAFEF00D, 3'b010);
    t.stall = 1'b1;
    repeat (3) begin
      step(t);
      check("stall_en", 32'(o_wr_en), 32'h1);
      check("stall_idx", 32'(o_wr_idx), 32'h7);
      check("stall_data", o_wr_data, 32'h11223344);
    end
    t.flush = 1'b1;
    t.reg2  = 32'h55555555;
    step(t);
    check("flush_en", 32'(o_wr_en), 32'h0);
    step(ld(32'h20, 3'b010, 5'd8));
    check("no_store_lw", o_wr_data, 32'h11223344);

`ifdef MEM_WB_MISALIGN_TRAP_EN
    step(st(32'h21, 32'h0000FFFF, 3'b001));
    check("mis_sh", 32'(o_misaligned), 32'h1);
    step(idle());
    check("mis_pulse_end", 32'(o_misaligned), 32'h0);
    step(ld(32'h20, 3'b010, 5'd8));
    check("mis_sh_no_write", o_wr_data, 32'h11223344);
    step(ld(32'h22, 3'b010, 5'd9));
    check("mis_lw_flag", 32'(o_misaligned), 32'h1);
    check("mis_lw_en", 32'(o_wr_en), 32'h0);
`endif

    for (int i = 0; i < 400; i++) step(rand_instr());

    step(st(32'h14, 32'h0BADF00D, 3'b010));
    drive(idle());
    drain();
    drive(st(32'h14, 32'h77777777, 3'b010));
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_en", 32'(o_wr_en), 32'h0);
    check("async_rst_idx", 32'(o_wr_idx), 32'h0);
    check("async_rst_data", o_wr_data, 32'h0);
    @(posedge clk);
    #1;
    drive(idle());
    rst  = 1'b1;
    prev = '{en: 1'b0, idx: 5'd0, data: 32'h0, mis: 1'b0, chk: 1'b1};
    step(ld(32'h14, 3'b010, 5'd3));
    check("lost_store_lw", o_wr_data, 32'h0BADF00D);

    drive(idle());
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory and writeback stage of the RISC-V pipeline.
- Consumes execute-stage results and performs data-memory loads and stores.
- Drives the register-file write port of the decode stage: write enable, index and data back into decode.
- Contains the data RAM, with a synchronous read and a synchronous byte-enabled write, plus the MEM/WB pipeline register.

Parameters:
- DMEM_SIZE, 512, data RAM depth in 32-bit words; power of two.
- ADDR_W, 9, word-address width; equals log2(DMEM_SIZE).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hold stage state; no store commit.
- flush  input  1  squash the incoming instruction.
- i_alu_result  input  32  ALU result; memory byte address for loads/stores.
- i_reg2  input  32  store data (rs2).
- i_pc4  input  32  PC+4, for JAL/JALR writeback.
- i_func3  input  3  load/store width and sign.
- i_mem_w_en  input  1  store instruction.
- i_w_idx  input  5  destination register.
- i_wb_sel  input  2  00 ALU, 01 memory, 10 PC+4, 11 ALU.
- i_wb_en  input  1  instruction writes rd.
- o_wr_en  output  1  register-file write enable to decode.
- o_wr_idx  output  5  register-file write index.
- o_wr_data  output  32  register-file write data.
- o_misaligned  output  1  misaligned access flag; present only with the macro.

Behaviour:
- Reset (rst low, async):
  - MEM/WB register cleared: o_wr_en=0, o_wr_idx=0, o_wr_data=0, o_misaligned=0.
  - RAM contents not reset.
- Latency: instruction presented in cycle N appears on o_wr_* in cycle N+1.
- MEM/WB register captures: wb_en, w_idx, wb_sel, func3, addr[1:0], alu_result, pc4.
- RAM read address register captures addr[ADDR_W+1:2] at the end of cycle N.
  - Word index wraps modulo DMEM_SIZE; upper address bits are ignored.
- Store commit: at the end of cycle N when i_mem_w_en=1, stall=0 and flush=0.
  - func3 000 SB: one byte lane selected by addr[1:0]; data = i_reg2[7:0].
  - func3 001 SH: lanes {addr[1]*2, +1}; data = i_reg2[15:0].
  - func3 010 SW: all four lanes.
  - Other func3 values: no write.
  - Byte order is little-endian.
- Load formatting (combinational in N+1, from RAM output and registered addr[1:0] and func3):
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend selected halfword.
  - 100 LBU: zero-extend selected byte.
  - 101 LHU: zero-extend selected halfword.
  - 010, 011, 110, 111: full word.
- o_wr_data mux by registered wb_sel: ALU result, formatted load, or PC+4.
- o_wr_en = registered wb_en AND (registered w_idx != 0). x0 is never written.
- Store then load to the same word in consecutive cycles: the load returns the newly stored data.
- stall=1:
  - MEM/WB register and RAM read address register hold.
  - RAM output does not change; o_wr_* stable.
  - No store is committed.
- flush=1:
  - Register loads a bubble: wb_en=0, other fields don't-care.
  - No store is committed.
  - flush takes priority over stall.
- Reset asserted mid-stall or mid-store: the register clears immediately; a store whose edge has not occurred is lost.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is detected: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned store: the write is suppressed.
  - Misaligned load: the registered wb_en is forced 0.
  - o_misaligned is registered; it pulses 1 in cycle N+1 for the offending instruction and is 0 after a flush bubble.
- Undefined:
  - o_misaligned is tied 0.
  - Address bits below access size are ignored: LH/SH use addr[1] only; LW/SW ignore addr[1:0].

Test Plan:
- Reset: rst=0 while stimulus toggles -> o_wr_en=0, o_wr_idx=0, o_wr_data=0 asynchronously; after release, idle inputs keep o_wr_en=0.
- SW addr 0x10, data 0x8899AABB; next cycle LB addr 0x13, rd=5 -> o_wr_en=1, idx=5, data=0xFFFFFF88. LBU addr 0x13 -> 0x00000088. LH addr 0x10 -> 0xFFFFAABB.
- SB 0x11, data 0x12 over word 0x8899AABB at 0x10; then LW 0x10 -> 0x889912BB. Address 0x810 with DMEM_SIZE=512 aliases 0x10.
- JAL writeback: wb_sel=10, pc4=0x104, rd=1 -> o_wr_data=0x104 in N+1. Same with rd=0 -> o_wr_en=0.
- stall held 3 cycles during a SW -> RAM unchanged and o_wr_* constant; stall+flush together -> bubble (o_wr_en=0), no store.
- With MEM_WB_MISALIGN_TRAP_EN: SH addr 0x21 -> o_misaligned=1 for one cycle and memory unchanged; LW addr 0x22 -> o_misaligned=1 and o_wr_en=0.
